k10_uart_tx_sched: RTL and testbench

K10_UART_TX_SCHED -- requirements
Module: k10_uart_tx_sched

---
 rtl/k10_uart_tx_sched.sv | 184 ++++++++++++++++++
 tb/tb_k10_uart_tx_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k10_uart_tx_sched.sv
// k10_uart_tx_sched: two-requester byte scheduler for an AXI4-lite UART.
// After reset it optionally programs the baud divisor, then serves bytes
// round-robin. Each byte is sent only once the UART status bit0 reports
// space: poll STATUS (0x04), and on bit0=1 write the byte to TXDATA (0x00).
// The bus carries a single outstanding transaction at a time.
module k10_uart_tx_sched #(
  parameter logic [31:0] UART_BASE = 32'h0000_0000,
  parameter logic [31:0] BAUD_DIV  = 32'd434
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  input  logic [15:0] i_req_data,
  output logic [1:0]  o_req_ready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_INIT_WR,
    S_INIT_B,
    S_IDLE,
    S_POLL_AR,
    S_POLL_R,
    S_TX_WR,
    S_TX_B
  } state_t;

  // A zero divisor means the UART keeps its own default: skip the init write.
  localparam state_t RST_STATE = (BAUD_DIV != 32'd0) ? S_INIT_WR : S_IDLE;

  state_t      r_state;
  state_t      w_next;
  logic        r_run;        // low while reset is asserted; masks every output
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_last_grant; // index of the requester granted most recently
  logic [7:0]  r_byte;
  logic        r_err;

  logic        w_in_wr;
  logic        w_in_b;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_r_hs;
  logic        w_wr_both;
  logic [1:0]  w_grant;
  logic        w_unused;

  // Only bit0 of STATUS matters.
  assign w_unused = ^m_axi_rdata[31:1];

  assign w_in_wr = (r_state == S_INIT_WR) || (r_state == S_TX_WR);
  assign w_in_b  = (r_state == S_INIT_B)  || (r_state == S_TX_B);

  // Address/data are decoded from state and the captured byte only, so they
  // cannot move while the matching valid is high.
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awaddr  = (r_state == S_INIT_WR) ? (UART_BASE + 32'h0000_000C) : UART_BASE;
  assign m_axi_wdata   = (r_state == S_INIT_WR) ? BAUD_DIV : {24'h00_0000, r_byte};
  assign m_axi_wstrb   = (r_state == S_INIT_WR) ? 4'hF : 4'h1;
  assign m_axi_araddr  = UART_BASE + 32'h0000_0004;

  assign m_axi_awvalid = r_run & w_in_wr & ~r_aw_done;
  assign m_axi_wvalid  = r_run & w_in_wr & ~r_w_done;
  assign m_axi_bready  = r_run & w_in_b;
  assign m_axi_arvalid = r_run & (r_state == S_POLL_AR);
  assign m_axi_rready  = r_run & (r_state == S_POLL_R);

  assign w_aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_w_hs    = m_axi_wvalid  & m_axi_wready;
  assign w_b_hs    = m_axi_bready  & m_axi_bvalid;
  assign w_r_hs    = m_axi_rready  & m_axi_rvalid;
  assign w_wr_both = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  assign o_req_ready = w_grant;
  assign o_busy      = r_run & (r_state != S_IDLE);
  assign o_err       = r_err;

  // Round-robin arbitration: on a tie the requester not served last wins.
  always_comb begin
    w_grant = 2'b00;
    if (r_run && (r_state == S_IDLE)) begin
      case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Next-state decode for the scheduler.
  always_comb begin
    w_next = r_state;
    if (r_run) begin
      case (r_state)
        S_INIT_WR: if (w_wr_both)       w_next = S_INIT_B;
        S_INIT_B:  if (m_axi_bvalid)    w_next = S_IDLE;
        S_IDLE:    if (w_grant != 2'b00) w_next = S_POLL_AR;
        S_POLL_AR: if (m_axi_arready)   w_next = S_POLL_R;
        S_POLL_R: begin
          if (m_axi_rvalid) begin
            // An error response counts as "no space": poll again.
            if ((m_axi_rresp == 2'b00) && m_axi_rdata[0]) w_next = S_TX_WR;
            else                                          w_next = S_POLL_AR;
          end
        end
        S_TX_WR:   if (w_wr_both)       w_next = S_TX_B;
        S_TX_B:    if (m_axi_bvalid)    w_next = S_IDLE;
        default:                        w_next = RST_STATE;
      endcase
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RST_STATE;
    else          r_state <= w_next;
  end

  // Output enable: outputs stay quiet until the first clock after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  // Per-channel write handshake tracking, cleared whenever the state changes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_next != r_state) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Capture the granted byte and remember who was served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_byte       <= 8'h00;
    end else if (w_grant != 2'b00) begin
      r_last_grant <= w_grant[1];
      r_byte       <= w_grant[1] ? i_req_data[15:8] : i_req_data[7:0];
    end
  end

  // Sticky error flag for any non-OKAY write or read response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if ((w_b_hs && (m_axi_bresp != 2'b00)) ||
                 (w_r_hs && (m_axi_rresp != 2'b00))) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_k10_uart_tx_sched.sv
// Directed bench for k10_uart_tx_sched with a small AXI4-lite UART slave.
module tb_k10_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b1, wready = 1'b1, arready = 1'b1;
  logic        bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic        busy, err;

  int vectors = 0;
  int errs = 0;

  // Slave model state and transaction logs
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          busy_until = 0;   // reads with index below this return bit0=0
  int          err_idx = -1;     // write index that receives SLVERR
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_l = '0, wd_l = '0;
  logic [3:0]  ws_l = '0;
  logic        ovl = 1'b0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [3:0]  wr_strb [0:63];
  logic [31:0] rd_addr [0:63];

  wire s_aw_hs = awvalid && awready;
  wire s_w_hs  = wvalid && wready;
  wire s_done  = (aw_got || s_aw_hs) && (w_got || s_w_hs);

  always #5 clk = ~clk;

  k10_uart_tx_sched dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .o_busy(busy), .o_err(err)
  );

  // UART register slave: logs writes/reads and answers with B/R beats.
  always @(posedge clk) begin
    if (awvalid && arvalid) ovl <= 1'b1;
    if (!rst_n) begin
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (s_done && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (wr_cnt == err_idx) ? 2'b10 : 2'b00;
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] <= s_aw_hs ? awaddr : aw_l;
          wr_data[wr_cnt] <= s_w_hs ? wdata : wd_l;
          wr_strb[wr_cnt] <= s_w_hs ? wstrb : ws_l;
        end
        wr_cnt <= wr_cnt + 1;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (s_aw_hs) begin aw_got <= 1'b1; aw_l <= awaddr; end
        if (s_w_hs)  begin w_got <= 1'b1; wd_l <= wdata; ws_l <= wstrb; end
      end
      if (arvalid && arready && !rvalid) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        rdata  <= (rd_cnt < busy_until) ? 32'h0 : 32'h1;
        if (rd_cnt < 64) rd_addr[rd_cnt] <= araddr;
        rd_cnt <= rd_cnt + 1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the scheduler to return to IDLE.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Present one request pattern in IDLE and check the grant pulse.
  task automatic grant(input string tag, input logic [1:0] v, input logic [15:0] d,
                       input logic [1:0] exp);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1 check({tag, "_ready"}, {30'd0, req_ready}, {30'd0, exp});
    @(negedge clk);
    req_valid = 2'b00;
    #1 check({tag, "_ready_off"}, {30'd0, req_ready}, 32'd0);
  endtask

  int w0, r0, ng;
  logic [1:0] g [0:3];

  initial begin
    // Reset asserted: everything quiet
    repeat (3) @(negedge clk);
    check("rst_awvalid", {31'd0, awvalid}, 0);
    check("rst_wvalid",  {31'd0, wvalid}, 0);
    check("rst_arvalid", {31'd0, arvalid}, 0);
    check("rst_busy",    {31'd0, busy}, 0);
    check("rst_err",     {31'd0, err}, 0);
    check("rst_ready",   {30'd0, req_ready}, 0);

    // Init write of the baud divisor
    rst_n = 1'b1;
    wait_idle("init");
    check("init_wrcnt", wr_cnt, 1);
    check("init_addr",  wr_addr[0], 32'h0C);
    check("init_data",  wr_data[0], 32'h1B2);
    check("init_strb",  {28'd0, wr_strb[0]}, 32'hF);
    check("init_rdcnt", rd_cnt, 0);

    // Single byte from requester 0, UART ready at first poll
    w0 = wr_cnt; r0 = rd_cnt;
    grant("b41", 2'b01, 16'h0041, 2'b01);
    wait_idle("b41");
    check("b41_reads",  rd_cnt - r0, 1);
    check("b41_raddr",  rd_addr[r0], 32'h04);
    check("b41_writes", wr_cnt - w0, 1);
    check("b41_waddr",  wr_addr[w0], 32'h00);
    check("b41_wdata",  wr_data[w0], 32'h41);
    check("b41_wstrb",  {28'd0, wr_strb[w0]}, 32'h1);
    check("prot", {26'd0, awprot, arprot}, 0);

    // Three busy polls, then ready: four reads and one write
    w0 = wr_cnt; r0 = rd_cnt;
    busy_until = rd_cnt + 3;
    grant("b5a", 2'b10, 16'h5A00, 2'b10);
    repeat (6) @(negedge clk);
    req_data = 16'hFFFF;  // ungranted data change must not matter
    check("b5a_nowr_early", wr_cnt - w0, 0);
    wait_idle("b5a");
    check("b5a_reads",  rd_cnt - r0, 4);
    check("b5a_writes", wr_cnt - w0, 1);
    check("b5a_wdata",  wr_data[w0], 32'h5A);

    // Both requesters held valid: grants alternate starting with req0
    w0 = wr_cnt;
    g[0] = 0; g[1] = 0; g[2] = 0; g[3] = 0;
    ng = 0;
    @(negedge clk);
    req_valid = 2'b11;
    req_data  = 16'h55AA;
    for (int c = 0; c < 400 && ng < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        g[ng] = req_ready;
        ng++;
      end
      if (ng < 4) @(negedge clk);
    end
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle("rr");
    check("rr_g0", {30'd0, g[0]}, 32'h1);
    check("rr_g1", {30'd0, g[1]}, 32'h2);
    check("rr_g2", {30'd0, g[2]}, 32'h1);
    check("rr_g3", {30'd0, g[3]}, 32'h2);
    check("rr_writes", wr_cnt - w0, 4);
    check("rr_d0", wr_data[w0],     32'hAA);
    check("rr_d1", wr_data[w0 + 1], 32'h55);
    check("rr_d2", wr_data[w0 + 2], 32'hAA);
    check("rr_d3", wr_data[w0 + 3], 32'h55);

    // SLVERR on the TX write: sticky error, next byte still served
    err_idx = wr_cnt;
    check("err_before", {31'd0, err}, 0);
    grant("b33", 2'b01, 16'h0033, 2'b01);
    wait_idle("b33");
    check("err_set", {31'd0, err}, 1);
    w0 = wr_cnt;
    grant("b77", 2'b10, 16'h7700, 2'b10);
    wait_idle("b77");
    check("b77_wdata", wr_data[w0], 32'h77);
    check("err_sticky", {31'd0, err}, 1);

    // Reset while polling: abandon, re-init, pending byte dropped
    busy_until = rd_cnt + 1000;
    grant("b99", 2'b01, 16'h0099, 2'b01);
    for (int c = 0; c < 50 && !rready; c++) @(negedge clk);
    check("b99_in_pollr", {31'd0, rready}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_arvalid", {31'd0, arvalid}, 0);
    check("mid_rst_rready",  {31'd0, rready}, 0);
    check("mid_rst_awvalid", {31'd0, awvalid}, 0);
    check("mid_rst_busy",    {31'd0, busy}, 0);
    check("mid_rst_err",     {31'd0, err}, 0);
    repeat (2) @(negedge clk);
    busy_until = 0;
    w0 = wr_cnt; r0 = rd_cnt;
    rst_n = 1'b1;
    wait_idle("reinit");
    check("reinit_writes", wr_cnt - w0, 1);
    check("reinit_addr",   wr_addr[w0], 32'h0C);
    check("reinit_data",   wr_data[w0], 32'h1B2);
    check("reinit_reads",  rd_cnt - r0, 0);

    // last_grant back to 1 after reset: req0 wins the tie
    w0 = wr_cnt;
    grant("tie", 2'b11, 16'h2211, 2'b01);
    wait_idle("tie");
    check("tie_wdata", wr_data[w0], 32'h11);
    check("no_aw_ar_overlap", {31'd0, ovl}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
